// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x oversampled) feeding a first-word-fall-through receive FIFO.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned  FifoDepth = 8,
    localparam int unsigned CntW      = $clog2(FifoDepth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [15:0]     clk_div_i,
    input  logic            rx_i,
    output logic [7:0]      data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CntW-1:0] fifo_count_o,
    output logic            frame_err_o,
    output logic            overrun_o,
    output logic            busy_o
);

    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned DivW  = 16;
    localparam int unsigned TickW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t state_q;

    logic            rx_meta;
    logic            rx_s;
    logic [DivW-1:0] div_q;
    logic [DivW-1:0] div_cnt;
    logic [TickW-1:0] tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_q;

    logic [DivW-1:0] div_eff_c;
    logic            tick_c;
    logic            start_c;
    logic            push_c;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic            pop_c;
    logic            full_c;
    logic            push_ok_c;
    logic            ovr_c;
    logic [PtrW-1:0] rd_next_c;
    logic [CntW-1:0] count_next_c;
    logic [7:0]      head_c;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Tick qualification, start detection and the byte-complete push strobe.
    always_comb begin
        div_eff_c = (clk_div_i == '0) ? DivW'(1) : clk_div_i;
        tick_c    = (state_q != ST_IDLE) && (div_cnt == (div_q - DivW'(1)));
        start_c   = en_i && (state_q == ST_IDLE) && !rx_s;
        push_c    = en_i && (state_q == ST_STOP) && tick_c &&
                    (tick_cnt == TickW'(15)) && rx_s;
    end

    // Oversample tick generator; the divider is re-latched only at frame start or tick-counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= DivW'(1);
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (start_c) begin
            div_q    <= div_eff_c;
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state_q != ST_IDLE) begin
            if (tick_c) begin
                div_cnt  <= '0;
                tick_cnt <= ((state_q == ST_START) && (tick_cnt == TickW'(7))) ?
                            TickW'(0) : tick_cnt + TickW'(1);
                if (tick_cnt == TickW'(15)) begin
                    div_q <= div_eff_c;
                end
            end else begin
                div_cnt <= div_cnt + DivW'(1);
            end
        end
    end

    // Receive FSM with registered busy and frame-error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_idx     <= '0;
            shift_q     <= '0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (!en_i) begin
                state_q <= ST_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            busy_o  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (tick_c && (tick_cnt == TickW'(7))) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_o  <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (tick_c && (tick_cnt == TickW'(15))) begin
                            shift_q <= {rx_s, shift_q[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state_q <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (tick_c && (tick_cnt == TickW'(15))) begin
                            if (rx_s) begin
                                state_q <= ST_IDLE;
                                busy_o  <= 1'b0;
                            end else begin
                                state_q     <= ST_BRK;
                                frame_err_o <= 1'b1;
                            end
                        end
                    end
                    ST_BRK: begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // FIFO next-state: push/pop arbitration and the next head value (forwarded when writing into an empty slot).
    always_comb begin
        pop_c        = valid_o && ready_i;
        full_c       = (fifo_count_o == CntW'(FifoDepth));
        push_ok_c    = push_c && (!full_c || pop_c);
        ovr_c        = push_c && !push_ok_c;
        rd_next_c    = pop_c ? rd_ptr + PtrW'(1) : rd_ptr;
        count_next_c = fifo_count_o;
        if (push_ok_c && !pop_c) begin
            count_next_c = fifo_count_o + CntW'(1);
        end else if (!push_ok_c && pop_c) begin
            count_next_c = fifo_count_o - CntW'(1);
        end
        head_c = 8'h00;
        if (count_next_c != '0) begin
            if (push_ok_c && (rd_next_c == wr_ptr)) begin
                head_c = shift_q;
            end else begin
                head_c = mem[rd_next_c];
            end
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    // FIFO pointers, occupancy and registered read-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count_o <= '0;
            valid_o      <= 1'b0;
            data_o       <= 8'h00;
            overrun_o    <= 1'b0;
        end else begin
            rd_ptr       <= rd_next_c;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            fifo_count_o <= count_next_c;
            valid_o      <= (count_next_c != '0);
            data_o       <= head_c;
            overrun_o    <= ovr_c;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at clk_div_i = 4 (64 clk cycles per bit).
module tb_uart_rx_fifo;

    localparam int unsigned CntW = 4;
    localparam int          BitCyc = 64;

    logic            clk;
    logic            rst_n;
    logic            en_i;
    logic [15:0]     clk_div_i;
    logic            rx_i;
    logic [7:0]      data_o;
    logic            valid_o;
    logic            ready_i;
    logic [CntW-1:0] fifo_count_o;
    logic            frame_err_o;
    logic            overrun_o;
    logic            busy_o;

    int checks   = 0;
    int failures = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_both   = 0;
    int n_pop    = 0;

    uart_rx_fifo #(.FifoDepth(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .clk_div_i    (clk_div_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fifo_count_o (fifo_count_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and handshake event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (frame_err_o && overrun_o) n_both++;
        if (valid_o && ready_i) n_pop++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one 8N1 frame starting at a negedge; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (BitCyc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (BitCyc) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (BitCyc) @(negedge clk);
    endtask

    task automatic fill_test1234();
        logic [7:0] s [8];
        s = '{8'h54, 8'h65, 8'h73, 8'h74, 8'h31, 8'h32, 8'h33, 8'h34};
        for (int i = 0; i < 8; i++) send_byte(s[i], 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h exp 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
        checks++; if (fifo_count_o !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d exp 0", fifo_count_o); end
        checks++; if ({frame_err_o, overrun_o, busy_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b exp 000", {frame_err_o, overrun_o, busy_o}); end
    endtask

    task automatic test_single();
        int rise, vcnt, e0, o0;
        logic [7:0] d;
        rise = -1; vcnt = 0; d = 8'h00; e0 = n_ferr; o0 = n_ovr;
        ready_i = 1'b1;
        fork
            send_byte(8'h54, 1'b1);
            for (int c = 1; c <= 700; c++) begin
                @(negedge clk);
                if (valid_o) begin
                    if (rise < 0) begin rise = c; d = data_o; end
                    vcnt++;
                end
            end
        join
        checks++; if (rise < 577 || rise > 616) begin failures++; $display("FAIL single_latency: got %0d exp 577..616", rise); end
        checks++; if (d !== 8'h54) begin failures++; $display("FAIL single_data: got %h exp 54", d); end
        checks++; if (vcnt != 1) begin failures++; $display("FAIL single_valid_width: got %0d exp 1", vcnt); end
        checks++; if ((n_ferr - e0) + (n_ovr - o0) != 0) begin failures++; $display("FAIL single_errors: got %0d exp 0", (n_ferr - e0) + (n_ovr - o0)); end
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int o0;
        logic [7:0] s [8];
        s = '{8'h54, 8'h65, 8'h73, 8'h74, 8'h31, 8'h32, 8'h33, 8'h34};
        o0 = n_ovr;
        ready_i = 1'b0;
        fill_test1234();
        repeat (20) @(negedge clk);
        checks++; if (fifo_count_o !== 4'd8) begin failures++; $display("FAIL b2b_count: got %0d exp 8", fifo_count_o); end
        checks++; if (n_ovr - o0 != 0) begin failures++; $display("FAIL b2b_overrun: got %0d exp 0", n_ovr - o0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== s[i]) begin failures++; $display("FAIL b2b_drain[%0d]: got v=%b %h exp v=1 %h", i, valid_o, data_o, s[i]); end
            ready_i = 1'b1;
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || fifo_count_o !== 4'd0 || data_o !== 8'h00) begin failures++; $display("FAIL b2b_empty: got v=%b cnt=%0d d=%h exp v=0 cnt=0 d=00", valid_o, fifo_count_o, data_o); end
    endtask

    task automatic test_overrun();
        int o0, p0;
        logic [7:0] s [8];
        s = '{8'h65, 8'h73, 8'h74, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA5};
        ready_i = 1'b0;
        fill_test1234();
        o0 = n_ovr;
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_ovr - o0 != 1) begin failures++; $display("FAIL ovr_pulse: got %0d exp 1", n_ovr - o0); end
        checks++; if (fifo_count_o !== 4'd8) begin failures++; $display("FAIL ovr_count: got %0d exp 8", fifo_count_o); end
        o0 = n_ovr; p0 = n_pop;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (610) @(posedge clk);
                @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (n_ovr - o0 != 0) begin failures++; $display("FAIL ovr_simul_pulse: got %0d exp 0", n_ovr - o0); end
        checks++; if (n_pop - p0 != 1) begin failures++; $display("FAIL ovr_simul_pop: got %0d exp 1", n_pop - p0); end
        checks++; if (fifo_count_o !== 4'd8) begin failures++; $display("FAIL ovr_simul_count: got %0d exp 8", fifo_count_o); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== s[i]) begin failures++; $display("FAIL ovr_drain[%0d]: got v=%b %h exp v=1 %h", i, valid_o, data_o, s[i]); end
            ready_i = 1'b1;
            @(negedge clk);
        end
        ready_i = 1'b0;
        checks++; if (fifo_count_o !== 4'd0) begin failures++; $display("FAIL ovr_empty: got %0d exp 0", fifo_count_o); end
    endtask

    task automatic test_frame_err();
        int e0;
        e0 = n_ferr;
        ready_i = 1'b0;
        send_byte(8'h55, 1'b0);
        repeat (BitCyc) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ferr_break_busy: got %b exp 1", busy_o); end
        repeat (2 * BitCyc) @(negedge clk);
        rx_i = 1'b1;
        repeat (BitCyc) @(negedge clk);
        checks++; if (n_ferr - e0 != 1) begin failures++; $display("FAIL ferr_pulses: got %0d exp 1", n_ferr - e0); end
        checks++; if (fifo_count_o !== 4'd0 || busy_o !== 1'b0) begin failures++; $display("FAIL ferr_no_push: got cnt=%0d busy=%b exp cnt=0 busy=0", fifo_count_o, busy_o); end
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (fifo_count_o !== 4'd1 || data_o !== 8'h3C) begin failures++; $display("FAIL ferr_next_byte: got cnt=%0d d=%h exp cnt=1 d=3c", fifo_count_o, data_o); end
        checks++; if (n_ferr - e0 != 1) begin failures++; $display("FAIL ferr_total: got %0d exp 1", n_ferr - e0); end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_glitch();
        int e0, o0;
        e0 = n_ferr; o0 = n_ovr;
        rx_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise: got %b exp 1", busy_o); end
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop: got %b exp 0", busy_o); end
        checks++; if (fifo_count_o !== 4'd0 || valid_o !== 1'b0) begin failures++; $display("FAIL glitch_no_push: got cnt=%0d v=%b exp 0 0", fifo_count_o, valid_o); end
        checks++; if ((n_ferr - e0) + (n_ovr - o0) != 0) begin failures++; $display("FAIL glitch_errors: got %0d exp 0", (n_ferr - e0) + (n_ovr - o0)); end
    endtask

    task automatic test_enable();
        int e0;
        logic b0;
        e0 = n_ferr; b0 = 1'b1;
        ready_i = 1'b0;
        fork
            send_byte(8'h0F, 1'b1);
            begin
                repeat (5 * BitCyc + 32) @(negedge clk);
                en_i = 1'b0;
                @(negedge clk);
                b0 = busy_o;
            end
        join
        checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL en_busy_drop: got %b exp 0", b0); end
        checks++; if (fifo_count_o !== 4'd0) begin failures++; $display("FAIL en_partial_dropped: got %0d exp 0", fifo_count_o); end
        en_i = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (fifo_count_o !== 4'd1 || data_o !== 8'h81) begin failures++; $display("FAIL en_rx_81: got cnt=%0d d=%h exp cnt=1 d=81", fifo_count_o, data_o); end
        checks++; if (n_ferr - e0 != 0) begin failures++; $display("FAIL en_errors: got %0d exp 0", n_ferr - e0); end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (fifo_count_o !== 4'd2 || data_o !== 8'h11) begin failures++; $display("FAIL rst_queued: got cnt=%0d d=%h exp cnt=2 d=11", fifo_count_o, data_o); end
        rx_i = 1'b0;
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fifo_count_o !== 4'd0 || valid_o !== 1'b0 || data_o !== 8'h00) begin failures++; $display("FAIL rst_async_fifo: got cnt=%0d v=%b d=%h exp 0 0 00", fifo_count_o, valid_o, data_o); end
        checks++; if ({frame_err_o, overrun_o, busy_o} !== 3'b000) begin failures++; $display("FAIL rst_async_flags: got %b exp 000", {frame_err_o, overrun_o, busy_o}); end
        rx_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (fifo_count_o !== 4'd0 || busy_o !== 1'b0) begin failures++; $display("FAIL rst_after: got cnt=%0d busy=%b exp 0 0", fifo_count_o, busy_o); end
    endtask

    initial begin
        rst_n     = 1'b0;
        en_i      = 1'b1;
        rx_i      = 1'b1;
        ready_i   = 1'b0;
        clk_div_i = 16'd4;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_enable();
        test_reset_mid();
        checks++; if (n_both != 0) begin failures++; $display("FAIL err_ovr_same_cycle: got %0d exp 0", n_both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
